// File: rtl/xy_vector_engine.sv
// Segment-command FIFO feeding a Bresenham rasteriser; emits one X/Y DAC point per sample tick.
// Blanked segments jump to their endpoint in a single beam-off sample.
module xy_vector_engine #(
    parameter int DAC_BITS      = 8,
    parameter int CLOCK_DIVIDER = 12,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                CLOCK_50,
    input  logic                KEY0,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [DAC_BITS-1:0] cmd_x0,
    input  logic [DAC_BITS-1:0] cmd_y0,
    input  logic [DAC_BITS-1:0] cmd_x1,
    input  logic [DAC_BITS-1:0] cmd_y1,
    input  logic                cmd_beam,
    output logic [DAC_BITS-1:0] x_dac,
    output logic [DAC_BITS-1:0] y_dac,
    output logic                beam_on,
    output logic                sample,
    output logic                busy
);
    localparam int DW = $clog2(CLOCK_DIVIDER);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 4 * DAC_BITS + 1;
    localparam int EW = DAC_BITS + 2;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLOCK_DIVIDER - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW} state_t;

    state_t r_state, w_next;
    logic [DW-1:0] r_div;
    logic          w_tick, w_push, w_pop, w_empty, w_full;
    logic [CW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr, r_rd;
    logic [CW-1:0] r_cmd;

    logic [DAC_BITS-1:0] r_cur_x, r_cur_y, r_end_x, r_end_y, r_dx, r_dy;
    logic [DAC_BITS-1:0] r_x_dac, r_y_dac;
    logic                r_sx, r_sy, r_beam, r_beam_on, r_sample;
    logic signed [EW-1:0] r_err, w_ld_err, w_err_nx;
    logic signed [EW:0]   w_e2, w_dx_s, w_dy_s;
    logic [DAC_BITS-1:0] w_c_x0, w_c_y0, w_c_x1, w_c_y1, w_ld_dx, w_ld_dy;
    logic                w_c_beam, w_at_end, w_step_x, w_step_y;

    // Free-running sample divider, never resynchronised to segment activity
    assign w_tick = (r_div == DIV_MAX);
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) r_div <= '0;
        else       r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;

    always_ff @(posedge CLOCK_50) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_beam};
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    assign w_at_end = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: if (!w_empty) begin
                w_pop  = 1'b1;
                w_next = S_LOAD;
            end
            S_LOAD: w_next = S_DRAW;
            S_DRAW: if (w_tick && (!r_beam || w_at_end)) begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    assign w_c_x0   = r_cmd[4*DAC_BITS -: DAC_BITS];
    assign w_c_y0   = r_cmd[3*DAC_BITS -: DAC_BITS];
    assign w_c_x1   = r_cmd[2*DAC_BITS -: DAC_BITS];
    assign w_c_y1   = r_cmd[DAC_BITS -: DAC_BITS];
    assign w_c_beam = r_cmd[0];
    assign w_ld_dx  = (w_c_x1 >= w_c_x0) ? w_c_x1 - w_c_x0 : w_c_x0 - w_c_x1;
    assign w_ld_dy  = (w_c_y1 >= w_c_y0) ? w_c_y1 - w_c_y0 : w_c_y0 - w_c_y1;
    assign w_ld_err = {2'b00, w_ld_dx} - {2'b00, w_ld_dy};

    // Both step decisions use the error from before this step's update
    assign w_e2     = {r_err, 1'b0};
    assign w_dx_s   = {3'b000, r_dx};
    assign w_dy_s   = {3'b000, r_dy};
    assign w_step_x = (w_e2 > -w_dy_s);
    assign w_step_y = (w_e2 < w_dx_s);
    assign w_err_nx = r_err - (w_step_x ? {2'b00, r_dy} : '0) + (w_step_y ? {2'b00, r_dx} : '0);

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_cmd     <= '0;
            r_cur_x   <= '0;
            r_cur_y   <= '0;
            r_end_x   <= '0;
            r_end_y   <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_sx      <= 1'b0;
            r_sy      <= 1'b0;
            r_err     <= '0;
            r_beam    <= 1'b0;
            r_x_dac   <= '0;
            r_y_dac   <= '0;
            r_beam_on <= 1'b0;
            r_sample  <= 1'b0;
        end else begin
            r_sample <= w_tick && (r_state == S_DRAW);
            if (w_pop) r_cmd <= r_mem[r_rd[AW-1:0]];
            if (r_state == S_LOAD) begin
                r_cur_x <= w_c_x0;
                r_cur_y <= w_c_y0;
                r_end_x <= w_c_x1;
                r_end_y <= w_c_y1;
                r_dx    <= w_ld_dx;
                r_dy    <= w_ld_dy;
                r_sx    <= (w_c_x1 < w_c_x0);
                r_sy    <= (w_c_y1 < w_c_y0);
                r_err   <= w_ld_err;
                r_beam  <= w_c_beam;
            end
            if (w_tick) begin
                if (r_state == S_DRAW) begin
                    r_x_dac   <= r_beam ? r_cur_x : r_end_x;
                    r_y_dac   <= r_beam ? r_cur_y : r_end_y;
                    r_beam_on <= r_beam;
                    if (r_beam && !w_at_end) begin
                        r_err <= w_err_nx;
                        if (w_step_x) r_cur_x <= r_sx ? r_cur_x - 1'b1 : r_cur_x + 1'b1;
                        if (w_step_y) r_cur_y <= r_sy ? r_cur_y - 1'b1 : r_cur_y + 1'b1;
                    end
                end else begin
                    r_beam_on <= 1'b0;
                end
            end
        end
    end

    assign x_dac   = r_x_dac;
    assign y_dac   = r_y_dac;
    assign beam_on = r_beam_on;
    assign sample  = r_sample;
    assign busy    = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_xy_vector_engine.sv
// Directed bench for xy_vector_engine: every sample pulse is logged and compared
// against hand-derived point lists, tick spacing and latency bounds.
module tb_xy_vector_engine;
    logic       CLOCK_50 = 1'b0;
    logic       KEY0 = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic       cmd_beam = 1'b0;
    logic [7:0] x_dac, y_dac;
    logic       beam_on, sample, busy;

    xy_vector_engine #(.DAC_BITS(8), .CLOCK_DIVIDER(12), .FIFO_DEPTH(4)) dut (
        .CLOCK_50(CLOCK_50), .KEY0(KEY0),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_beam(cmd_beam),
        .x_dac(x_dac), .y_dac(y_dac), .beam_on(beam_on), .sample(sample), .busy(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int qx[$], qy[$], qb[$], qc[$];

    // Sample log, taken 1ns after each rising edge
    always @(posedge CLOCK_50) begin
        cyc++;
        #1;
        if (KEY0 && sample) begin
            qx.push_back(int'(x_dac));
            qy.push_back(int'(y_dac));
            qb.push_back(int'(beam_on));
            qc.push_back(cyc);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_q();
        qx.delete(); qy.delete(); qb.delete(); qc.delete();
    endtask

    task automatic push_cmd(input int x0, input int y0, input int x1, input int y1,
                            input int b, output int stalls);
        cmd_x0 = 8'(x0); cmd_y0 = 8'(y0); cmd_x1 = 8'(x1); cmd_y1 = 8'(y1);
        cmd_beam = 1'(b);
        cmd_valid = 1'b1;
        stalls = 0;
        while (!cmd_ready && stalls < 5000) begin
            @(negedge CLOCK_50);
            stalls++;
        end
        n_chk++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL push_timeout: cmd_ready=%0b after %0d clocks, required 1", cmd_ready, stalls);
        end else begin
            @(negedge CLOCK_50);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_n(input int n, input int budget);
        int t = 0;
        while (qx.size() < n && t < budget) begin
            @(negedge CLOCK_50);
            t++;
        end
        n_chk++;
        if (qx.size() < n) begin
            n_fail++;
            $display("FAIL sample_timeout: got %0d samples, required %0d", qx.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge CLOCK_50);
        n_chk++; if (x_dac !== 8'd0)   begin n_fail++; $display("FAIL rst_x: got %0d want 0", x_dac); end
        n_chk++; if (y_dac !== 8'd0)   begin n_fail++; $display("FAIL rst_y: got %0d want 0", y_dac); end
        n_chk++; if (beam_on !== 1'b0) begin n_fail++; $display("FAIL rst_beam: got %b want 0", beam_on); end
        n_chk++; if (sample !== 1'b0)  begin n_fail++; $display("FAIL rst_sample: got %b want 0", sample); end
        n_chk++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        KEY0 = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        n_chk++; if (qx.size() !== 0) begin n_fail++; $display("FAIL rst_nosample: got %0d samples want 0", qx.size()); end
        n_chk++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_horizontal();
        int st, c0;
        clear_q();
        c0 = cyc;
        push_cmd(10, 20, 14, 20, 1, st);
        wait_n(5, 200);
        n_chk++;
        if (qc[0] - c0 < 3 || qc[0] - c0 > 14) begin
            n_fail++; $display("FAIL horiz_latency: got %0d clocks want 3..14", qc[0] - c0);
        end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (qx[i] !== 10 + i || qy[i] !== 20 || qb[i] !== 1) begin
                n_fail++;
                $display("FAIL horiz[%0d]: got (%0d,%0d,b%0d) want (%0d,20,b1)", i, qx[i], qy[i], qb[i], 10 + i);
            end
            if (i > 0) begin
                n_chk++;
                if (qc[i] - qc[i-1] !== 12) begin
                    n_fail++; $display("FAIL horiz_spacing[%0d]: got %0d want 12", i, qc[i] - qc[i-1]);
                end
            end
        end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL horiz_busy: got %b want 0", busy); end
        repeat (12) @(negedge CLOCK_50);
        n_chk++; if (beam_on !== 1'b0) begin n_fail++; $display("FAIL horiz_beam_off: got %b want 0", beam_on); end
        n_chk++; if (x_dac !== 8'd14)  begin n_fail++; $display("FAIL horiz_hold_x: got %0d want 14", x_dac); end
        n_chk++; if (qx.size() !== 5)  begin n_fail++; $display("FAIL horiz_extra: got %0d samples want 5", qx.size()); end
    endtask

    task automatic test_diagonal();
        int st;
        int ex[6] = '{0, 0, 1, 1, 2, 2};
        int ey[6] = '{0, 1, 2, 3, 4, 5};
        clear_q();
        push_cmd(0, 0, 2, 5, 1, st);
        wait_n(6, 200);
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (qx[i] !== ex[i] || qy[i] !== ey[i] || qb[i] !== 1) begin
                n_fail++;
                $display("FAIL diag[%0d]: got (%0d,%0d,b%0d) want (%0d,%0d,b1)", i, qx[i], qy[i], qb[i], ex[i], ey[i]);
            end
        end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL diag_idle: busy=%b want 0", busy); end
        repeat (24) @(negedge CLOCK_50);
        n_chk++; if (qx.size() !== 6) begin n_fail++; $display("FAIL diag_extra: got %0d samples want 6", qx.size()); end
    endtask

    task automatic test_descending();
        int st;
        clear_q();
        push_cmd(200, 100, 197, 100, 1, st);
        wait_n(4, 200);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (qx[i] !== 200 - i || qy[i] !== 100 || qb[i] !== 1) begin
                n_fail++;
                $display("FAIL desc[%0d]: got (%0d,%0d,b%0d) want (%0d,100,b1)", i, qx[i], qy[i], qb[i], 200 - i);
            end
        end
        repeat (24) @(negedge CLOCK_50);
        n_chk++; if (qx.size() !== 4) begin n_fail++; $display("FAIL desc_extra: got %0d samples want 4", qx.size()); end
    endtask

    task automatic test_blanked();
        int st;
        int ex[4] = '{255, 255, 254, 253};
        int eb[4] = '{0, 1, 1, 1};
        clear_q();
        push_cmd(0, 0, 255, 255, 0, st);
        push_cmd(255, 255, 253, 255, 1, st);
        wait_n(4, 200);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (qx[i] !== ex[i] || qy[i] !== 255 || qb[i] !== eb[i]) begin
                n_fail++;
                $display("FAIL blank[%0d]: got (%0d,%0d,b%0d) want (%0d,255,b%0d)", i, qx[i], qy[i], qb[i], ex[i], eb[i]);
            end
            if (i > 0) begin
                n_chk++;
                if (qc[i] - qc[i-1] !== 12) begin
                    n_fail++; $display("FAIL blank_spacing[%0d]: got %0d want 12", i, qc[i] - qc[i-1]);
                end
            end
        end
        repeat (24) @(negedge CLOCK_50);
        n_chk++; if (qx.size() !== 4) begin n_fail++; $display("FAIL blank_extra: got %0d samples want 4", qx.size()); end
    endtask

    task automatic test_fifo_full();
        int st, tot;
        int ex[111], ey[111];
        int tx[10] = '{10, 11, 20, 20, 30, 29, 40, 50, 51, 52};
        int ty[10] = '{10, 10, 20, 21, 30, 29, 40, 50, 50, 50};
        for (int i = 0; i <= 100; i++) begin ex[i] = i; ey[i] = 0; end
        for (int i = 0; i < 10; i++) begin ex[101 + i] = tx[i]; ey[101 + i] = ty[i]; end
        clear_q();
        tot = 0;
        push_cmd(0, 0, 100, 0, 1, st);   tot += st;
        push_cmd(10, 10, 11, 10, 1, st); tot += st;
        push_cmd(20, 20, 20, 21, 1, st); tot += st;
        push_cmd(30, 30, 29, 29, 1, st); tot += st;
        push_cmd(40, 40, 40, 40, 1, st); tot += st;
        n_chk++; if (tot !== 0) begin n_fail++; $display("FAIL fifo_first5_stall: got %0d stalls want 0", tot); end
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full_ready: got %b want 0", cmd_ready); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fifo_busy: got %b want 1", busy); end
        push_cmd(50, 50, 52, 50, 1, st);
        n_chk++; if (st < 100) begin n_fail++; $display("FAIL fifo_6th_stall: got %0d stalls want >=100", st); end
        n_chk++; if (qx.size() !== 101) begin n_fail++; $display("FAIL fifo_6th_after_pop: got %0d samples want 101", qx.size()); end
        wait_n(111, 3000);
        for (int i = 0; i < 111; i++) begin
            n_chk++;
            if (qx[i] !== ex[i] || qy[i] !== ey[i] || qb[i] !== 1) begin
                n_fail++;
                $display("FAIL fifo_seq[%0d]: got (%0d,%0d,b%0d) want (%0d,%0d,b1)", i, qx[i], qy[i], qb[i], ex[i], ey[i]);
            end
            if (i > 0) begin
                n_chk++;
                if (qc[i] - qc[i-1] !== 12) begin
                    n_fail++; $display("FAIL fifo_spacing[%0d]: got %0d want 12", i, qc[i] - qc[i-1]);
                end
            end
        end
        @(negedge CLOCK_50);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fifo_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int st;
        clear_q();
        push_cmd(0, 0, 200, 0, 1, st);
        push_cmd(5, 5, 6, 5, 1, st);
        push_cmd(7, 7, 8, 8, 1, st);
        wait_n(3, 200);
        KEY0 = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        n_chk++; if (x_dac !== 8'd0)     begin n_fail++; $display("FAIL mid_x: got %0d want 0", x_dac); end
        n_chk++; if (y_dac !== 8'd0)     begin n_fail++; $display("FAIL mid_y: got %0d want 0", y_dac); end
        n_chk++; if (beam_on !== 1'b0)   begin n_fail++; $display("FAIL mid_beam: got %b want 0", beam_on); end
        n_chk++; if (sample !== 1'b0)    begin n_fail++; $display("FAIL mid_sample: got %b want 0", sample); end
        n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
        KEY0 = 1'b1;
        repeat (40) @(negedge CLOCK_50);
        n_chk++; if (qx.size() !== 3) begin n_fail++; $display("FAIL mid_flushed: got %0d samples want 3", qx.size()); end
        n_chk++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL mid_idle_busy: got %b want 0", busy); end
        push_cmd(7, 9, 7, 9, 1, st);
        wait_n(4, 40);
        n_chk++;
        if (qx[3] !== 7 || qy[3] !== 9 || qb[3] !== 1) begin
            n_fail++; $display("FAIL mid_new_point: got (%0d,%0d,b%0d) want (7,9,b1)", qx[3], qy[3], qb[3]);
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_diagonal();
        test_descending();
        test_blanked();
        test_fifo_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
